mcalu_sched: RTL and testbench

Two-port issue scheduler and holding queue in front of the multi-cycle ALU (mcalu). It accepts ready operations from two execution reservation stations (exers0, exers1) and stores them in a DEPTH-entry circular queue. It resolves contention for the last free slot round-robin and presents queued operations to mcalu in enqueue order, one per accepted cycle, honoring mcalu backpressure. A ROB flush discards all queued work.

---
 rtl/mcalu_sched.sv | 119 +++++++++++
 tb/tb_mcalu_sched.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcalu_sched.sv
// Two-port issue scheduler: DEPTH-entry circular queue feeding mcalu in enqueue order.
// Latency: enqueue-to-issue 1 cycle, no bypass. Backpressure: a port stalls when the queue lacks space; head holds on mcalu_stall.
module mcalu_sched #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exers0_valid,
    input  logic [4:0]  exers0_op,
    input  logic [6:0]  exers0_robid,
    input  logic [5:0]  exers0_rd,
    input  logic [31:0] exers0_op1,
    input  logic [31:0] exers0_op2,
    output logic        sched_stall0,
    input  logic        exers1_valid,
    input  logic [4:0]  exers1_op,
    input  logic [6:0]  exers1_robid,
    input  logic [5:0]  exers1_rd,
    input  logic [31:0] exers1_op1,
    input  logic [31:0] exers1_op2,
    output logic        sched_stall1,
    output logic        sched_mcalu_issue,
    output logic [4:0]  sched_mcalu_op,
    output logic [6:0]  sched_mcalu_robid,
    output logic [5:0]  sched_mcalu_rd,
    output logic [31:0] sched_mcalu_op1,
    output logic [31:0] sched_mcalu_op2,
    input  logic        mcalu_stall,
    input  logic        rob_flush
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [4:0]  op;
        logic [6:0]  robid;
        logic [5:0]  rd;
        logic [31:0] op1;
        logic [31:0] op2;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d, wr1_idx;
    logic [CW-1:0] count_q, count_d, free;
    logic          rr_q, rr_d;
    logic          acc0, acc1, contend, deq;
    entry_t        in0, in1, hd;

    assign in0 = '{op: exers0_op, robid: exers0_robid, rd: exers0_rd, op1: exers0_op1, op2: exers0_op2};
    assign in1 = '{op: exers1_op, robid: exers1_robid, rd: exers1_rd, op1: exers1_op1, op2: exers1_op2};

    // Space is judged on the registered count only; a same-cycle dequeue frees nothing.
    assign free    = CW'(DEPTH) - count_q;
    assign contend = ~rob_flush & exers0_valid & exers1_valid & (free == CW'(1));

    always_comb begin
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (!rob_flush) begin
            if (free >= CW'(2)) begin
                acc0 = exers0_valid;
                acc1 = exers1_valid;
            end else if (free == CW'(1)) begin
                if (contend) begin
                    acc0 = ~rr_q;
                    acc1 = rr_q;
                end else begin
                    acc0 = exers0_valid;
                    acc1 = exers1_valid;
                end
            end
        end
    end

    assign sched_stall0      = exers0_valid & ~acc0 & ~rob_flush;
    assign sched_stall1      = exers1_valid & ~acc1 & ~rob_flush;
    assign sched_mcalu_issue = (count_q != '0) & ~rob_flush;
    assign deq               = sched_mcalu_issue & ~mcalu_stall;
    assign wr1_idx           = acc0 ? tail_q + PW'(1) : tail_q;

    always_comb begin
        head_d  = head_q + PW'(deq);
        tail_d  = tail_q + PW'(acc0) + PW'(acc1);
        count_d = count_q + CW'(acc0) + CW'(acc1) - CW'(deq);
        rr_d    = contend ? ~rr_q : rr_q;
        if (rob_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rr_q    <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rr_q    <= rr_d;
        end
    end

    // Entry storage needs no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (acc0) mem_q[tail_q]  <= in0;
        if (acc1) mem_q[wr1_idx] <= in1;
    end

    assign hd                = mem_q[head_q];
    assign sched_mcalu_op    = hd.op;
    assign sched_mcalu_robid = hd.robid;
    assign sched_mcalu_rd    = hd.rd;
    assign sched_mcalu_op1   = hd.op1;
    assign sched_mcalu_op2   = hd.op2;
endmodule

// File: tb/tb_mcalu_sched.sv
// Scenario bench for mcalu_sched with an issue-order scoreboard.
module tb_mcalu_sched;
    typedef struct packed {
        logic [4:0]  op;
        logic [6:0]  robid;
        logic [5:0]  rd;
        logic [31:0] op1;
        logic [31:0] op2;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exers0_valid = 1'b0, exers1_valid = 1'b0;
    logic [4:0]  exers0_op = '0, exers1_op = '0;
    logic [6:0]  exers0_robid = '0, exers1_robid = '0;
    logic [5:0]  exers0_rd = '0, exers1_rd = '0;
    logic [31:0] exers0_op1 = '0, exers0_op2 = '0, exers1_op1 = '0, exers1_op2 = '0;
    logic        sched_stall0, sched_stall1, sched_mcalu_issue;
    logic [4:0]  sched_mcalu_op;
    logic [6:0]  sched_mcalu_robid;
    logic [5:0]  sched_mcalu_rd;
    logic [31:0] sched_mcalu_op1, sched_mcalu_op2;
    logic        mcalu_stall = 1'b0;
    logic        rob_flush = 1'b0;

    int   errors = 0;
    int   checks = 0;
    ent_t sb[$];
    ent_t nil = '0;

    mcalu_sched #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .exers0_valid(exers0_valid), .exers0_op(exers0_op), .exers0_robid(exers0_robid),
        .exers0_rd(exers0_rd), .exers0_op1(exers0_op1), .exers0_op2(exers0_op2),
        .sched_stall0(sched_stall0),
        .exers1_valid(exers1_valid), .exers1_op(exers1_op), .exers1_robid(exers1_robid),
        .exers1_rd(exers1_rd), .exers1_op1(exers1_op1), .exers1_op2(exers1_op2),
        .sched_stall1(sched_stall1),
        .sched_mcalu_issue(sched_mcalu_issue), .sched_mcalu_op(sched_mcalu_op),
        .sched_mcalu_robid(sched_mcalu_robid), .sched_mcalu_rd(sched_mcalu_rd),
        .sched_mcalu_op1(sched_mcalu_op1), .sched_mcalu_op2(sched_mcalu_op2),
        .mcalu_stall(mcalu_stall), .rob_flush(rob_flush)
    );

    always #5 clk = ~clk;

    function automatic ent_t mk(input logic [6:0] id);
        ent_t e;
        e.op    = id[4:0] ^ 5'h15;
        e.robid = id;
        e.rd    = id[5:0] + 6'd1;
        e.op1   = {25'd0, id} * 32'd3 + 32'd1;
        e.op2   = {25'd0, id} ^ 32'hA5A5_0000;
        return e;
    endfunction

    // Drive one cycle's inputs at the falling edge, then settle before sampling.
    task automatic cyc(input logic v0, input ent_t e0, input logic v1, input ent_t e1,
                       input logic ms, input logic fl);
        @(negedge clk);
        exers0_valid = v0; exers0_op = e0.op; exers0_robid = e0.robid;
        exers0_rd = e0.rd; exers0_op1 = e0.op1; exers0_op2 = e0.op2;
        exers1_valid = v1; exers1_op = e1.op; exers1_robid = e1.robid;
        exers1_rd = e1.rd; exers1_op1 = e1.op1; exers1_op2 = e1.op2;
        mcalu_stall = ms;
        rob_flush = fl;
        #1;
    endtask

    // Every dequeue must match the oldest accepted op.
    always @(negedge clk) begin
        #2;
        if (!rst && sched_mcalu_issue && !mcalu_stall) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_issue: robid=%0d issued, expected nothing", sched_mcalu_robid);
            end else begin
                ent_t exp_e;
                ent_t got;
                exp_e = sb.pop_front();
                got = '{op: sched_mcalu_op, robid: sched_mcalu_robid, rd: sched_mcalu_rd,
                        op1: sched_mcalu_op1, op2: sched_mcalu_op2};
                if (got !== exp_e) begin
                    errors++;
                    $display("FAIL sb_issue_order: got=%h expected=%h", got, exp_e);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if ({sched_mcalu_issue, sched_stall0, sched_stall1} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: issue/s0/s1=%b expected 000",
                     {sched_mcalu_issue, sched_stall0, sched_stall1});
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        ent_t e;
        e = '{op: 5'h00, robid: 7'd3, rd: 6'd4, op1: 32'd7, op2: 32'd9};
        cyc(1, e, 0, nil, 0, 0);
        checks++;
        if (sched_stall0 !== 1'b0 || sched_mcalu_issue !== 1'b0) begin
            errors++;
            $display("FAIL single_accept: stall0=%b issue=%b expected 0 0", sched_stall0, sched_mcalu_issue);
        end
        sb.push_back(e);
        cyc(0, nil, 0, nil, 0, 0);
        checks++;
        if (sched_mcalu_issue !== 1'b1 || sched_mcalu_robid !== 7'd3 || sched_mcalu_op1 !== 32'd7) begin
            errors++;
            $display("FAIL single_issue: issue=%b robid=%0d op1=%0d expected 1 3 7",
                     sched_mcalu_issue, sched_mcalu_robid, sched_mcalu_op1);
        end
        cyc(0, nil, 0, nil, 0, 0);
        checks++;
        if (sched_mcalu_issue !== 1'b0) begin
            errors++;
            $display("FAIL single_drained: issue=%b expected 0", sched_mcalu_issue);
        end
    endtask

    task automatic test_fill_stalled();
        cyc(1, mk(0), 1, mk(1), 1, 0);
        checks++;
        if ({sched_stall0, sched_stall1} !== 2'b00) begin
            errors++;
            $display("FAIL fill_pair1: stalls=%b expected 00", {sched_stall0, sched_stall1});
        end
        sb.push_back(mk(0)); sb.push_back(mk(1));
        cyc(1, mk(2), 1, mk(3), 1, 0);
        checks++;
        if ({sched_stall0, sched_stall1} !== 2'b00) begin
            errors++;
            $display("FAIL fill_pair2: stalls=%b expected 00", {sched_stall0, sched_stall1});
        end
        sb.push_back(mk(2)); sb.push_back(mk(3));
        cyc(1, mk(4), 1, mk(5), 1, 0);
        checks++;
        if ({sched_stall0, sched_stall1} !== 2'b11 || sched_mcalu_robid !== 7'd0) begin
            errors++;
            $display("FAIL fill_full: stalls=%b head=%0d expected 11 0",
                     {sched_stall0, sched_stall1}, sched_mcalu_robid);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(0, nil, 0, nil, 0, 0);
            checks++;
            if (sched_mcalu_issue !== 1'b1 || sched_mcalu_robid !== 7'(k)) begin
                errors++;
                $display("FAIL fill_drain: issue=%b robid=%0d expected 1 %0d",
                         sched_mcalu_issue, sched_mcalu_robid, k);
            end
        end
        cyc(0, nil, 0, nil, 0, 0);
        checks++;
        if (sched_mcalu_issue !== 1'b0) begin
            errors++;
            $display("FAIL fill_empty: issue=%b expected 0", sched_mcalu_issue);
        end
    endtask

    task automatic test_round_robin();
        cyc(1, mk(10), 1, mk(11), 1, 0);
        sb.push_back(mk(10)); sb.push_back(mk(11));
        cyc(1, mk(12), 0, nil, 1, 0);
        sb.push_back(mk(12));
        cyc(1, mk(13), 1, mk(14), 1, 0);
        checks++;
        if ({sched_stall0, sched_stall1} !== 2'b01) begin
            errors++;
            $display("FAIL rr_first: stalls=%b expected 01", {sched_stall0, sched_stall1});
        end
        sb.push_back(mk(13));
        cyc(0, nil, 0, nil, 0, 0);
        cyc(1, mk(15), 1, mk(16), 1, 0);
        checks++;
        if ({sched_stall0, sched_stall1} !== 2'b10) begin
            errors++;
            $display("FAIL rr_second: stalls=%b expected 10", {sched_stall0, sched_stall1});
        end
        sb.push_back(mk(16));
        repeat (5) cyc(0, nil, 0, nil, 0, 0);
        checks++;
        if (sched_mcalu_issue !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL rr_drain: issue=%b pending=%0d expected 0 0", sched_mcalu_issue, sb.size());
        end
    endtask

    task automatic test_wrap();
        cyc(1, mk(20), 0, nil, 1, 0);
        sb.push_back(mk(20));
        cyc(1, mk(21), 1, mk(22), 1, 0);
        checks++;
        if ({sched_stall0, sched_stall1} !== 2'b00) begin
            errors++;
            $display("FAIL wrap_dual: stalls=%b expected 00", {sched_stall0, sched_stall1});
        end
        sb.push_back(mk(21)); sb.push_back(mk(22));
        cyc(0, nil, 1, mk(23), 1, 0);
        sb.push_back(mk(23));
        cyc(1, mk(30), 1, mk(31), 0, 0);
        checks++;
        if ({sched_stall0, sched_stall1} !== 2'b11 || sched_mcalu_issue !== 1'b1) begin
            errors++;
            $display("FAIL full_with_deq: stalls=%b issue=%b expected 11 1",
                     {sched_stall0, sched_stall1}, sched_mcalu_issue);
        end
        cyc(0, nil, 0, nil, 0, 0);
        cyc(1, mk(24), 1, mk(25), 1, 0);
        checks++;
        if ({sched_stall0, sched_stall1} !== 2'b00 || sched_mcalu_robid !== 7'd22) begin
            errors++;
            $display("FAIL wrap_refill: stalls=%b head=%0d expected 00 22",
                     {sched_stall0, sched_stall1}, sched_mcalu_robid);
        end
        sb.push_back(mk(24)); sb.push_back(mk(25));
        repeat (5) cyc(0, nil, 0, nil, 0, 0);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL wrap_drain: pending=%0d expected 0", sb.size());
        end
    endtask

    task automatic test_flush();
        cyc(1, mk(40), 1, mk(41), 1, 0);
        sb.push_back(mk(40)); sb.push_back(mk(41));
        cyc(1, mk(42), 0, nil, 1, 0);
        sb.push_back(mk(42));
        cyc(1, mk(43), 1, mk(44), 1, 1);
        checks++;
        if ({sched_mcalu_issue, sched_stall0, sched_stall1} !== 3'b000) begin
            errors++;
            $display("FAIL flush_cycle: issue/s0/s1=%b expected 000",
                     {sched_mcalu_issue, sched_stall0, sched_stall1});
        end
        sb.delete();
        cyc(0, nil, 0, nil, 0, 0);
        checks++;
        if (sched_mcalu_issue !== 1'b0) begin
            errors++;
            $display("FAIL flush_after: issue=%b expected 0", sched_mcalu_issue);
        end
        cyc(1, mk(50), 1, mk(51), 0, 0);
        checks++;
        if ({sched_stall0, sched_stall1} !== 2'b00) begin
            errors++;
            $display("FAIL flush_resume: stalls=%b expected 00", {sched_stall0, sched_stall1});
        end
        sb.push_back(mk(50)); sb.push_back(mk(51));
        repeat (3) cyc(0, nil, 0, nil, 0, 0);
        checks++;
        if (sb.size() != 0 || sched_mcalu_issue !== 1'b0) begin
            errors++;
            $display("FAIL flush_drain: pending=%0d issue=%b expected 0 0", sb.size(), sched_mcalu_issue);
        end
    endtask

    task automatic test_reset_full();
        cyc(1, mk(60), 1, mk(61), 1, 0);
        cyc(1, mk(62), 0, nil, 1, 0);
        cyc(1, mk(63), 1, mk(64), 1, 0);
        @(negedge clk);
        rst = 1'b1;
        exers0_valid = 1'b0; exers1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (sched_mcalu_issue !== 1'b0) begin
            errors++;
            $display("FAIL rst_full_issue: issue=%b expected 0", sched_mcalu_issue);
        end
        cyc(1, mk(70), 1, mk(71), 1, 0);
        checks++;
        if ({sched_stall0, sched_stall1} !== 2'b00) begin
            errors++;
            $display("FAIL rst_full_accept: stalls=%b expected 00", {sched_stall0, sched_stall1});
        end
        sb.push_back(mk(70)); sb.push_back(mk(71));
        cyc(1, mk(72), 0, nil, 1, 0);
        sb.push_back(mk(72));
        cyc(1, mk(73), 1, mk(74), 1, 0);
        checks++;
        if ({sched_stall0, sched_stall1} !== 2'b01) begin
            errors++;
            $display("FAIL rst_rr_cleared: stalls=%b expected 01", {sched_stall0, sched_stall1});
        end
        sb.push_back(mk(73));
        repeat (5) cyc(0, nil, 0, nil, 0, 0);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rst_drain: pending=%0d expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_stalled();
        test_round_robin();
        test_wrap();
        test_flush();
        test_reset_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
